// File: rtl/pagerank_iter_ctrl_if.sv
// Handshake bundle between the PageRank iteration controller and the
// scatter/gather threads. The master modport is the controller side and
// the slave modport is the environment that runs the scatter/gather phases.
interface pagerank_iter_ctrl_if #(
  parameter int DELTA_W = 32,
  parameter int PART_W  = 1,
  parameter int ITER_W  = 16
);
  logic               pagerank_enable;
  logic [DELTA_W-1:0] threshold;
  logic               scatter_start;
  logic [PART_W-1:0]  scatter_part;
  logic               scatter_done;
  logic               gather_start;
  logic [PART_W-1:0]  gather_part;
  logic               gather_done;
  logic               delta_valid;
  logic [DELTA_W-1:0] delta;
  logic [ITER_W-1:0]  iter_count;
  logic               busy;
  logic               pagerank_complete;
  logic               converged;

  modport master (
    input  pagerank_enable, threshold, scatter_done, gather_done,
           delta_valid, delta,
    output scatter_start, scatter_part, gather_start, gather_part,
           iter_count, busy, pagerank_complete, converged
  );

  modport slave (
    output pagerank_enable, threshold, scatter_done, gather_done,
           delta_valid, delta,
    input  scatter_start, scatter_part, gather_start, gather_part,
           iter_count, busy, pagerank_complete, converged
  );
endinterface

// File: rtl/pagerank_iter_ctrl.sv
// PageRank iteration controller: sequences scatter then gather over every
// partition, one partition at a time, and ends the run on convergence or
// at the iteration limit.
// Optional build macro PAGERANK_SUM_CONV_EN: the per-iteration delta
// accumulator becomes a saturating sum (L1 test) instead of a running max.
module pagerank_iter_ctrl #(
  parameter int NUM_PARTITIONS = 1,
  parameter int MAX_ITER       = 100,
  parameter int DELTA_W        = 32,
  parameter int ITER_W         = 16
) (
  input logic                  clock,
  input logic                  reset_n,
  pagerank_iter_ctrl_if.master bus
);
  localparam int PART_W = $clog2(NUM_PARTITIONS) + 1;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SC_ISSUE = 3'd1;
  localparam logic [2:0] SC_WAIT  = 3'd2;
  localparam logic [2:0] GA_ISSUE = 3'd3;
  localparam logic [2:0] GA_WAIT  = 3'd4;
  localparam logic [2:0] CHECK    = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;

  localparam logic [PART_W-1:0] LAST_PART  = PART_W'(NUM_PARTITIONS - 1);
  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

  logic [2:0]         state;
  logic [PART_W-1:0]  part;
  logic [ITER_W-1:0]  iter_q;
  logic [ITER_W-1:0]  iter_next;
  logic [DELTA_W-1:0] acc;
  logic [DELTA_W-1:0] acc_next;
  logic [DELTA_W-1:0] thr_q;
  logic               conv_q;
  logic               in_scatter;
  logic               in_gather;

  assign iter_next  = iter_q + ITER_W'(1);
  assign in_scatter = (state == SC_ISSUE) || (state == SC_WAIT);
  assign in_gather  = (state == GA_ISSUE) || (state == GA_WAIT);

`ifdef PAGERANK_SUM_CONV_EN
  logic [DELTA_W:0] acc_sum;
`endif

  // Fold one node delta into the per-iteration accumulator.
  always_comb begin
    acc_next = acc;
`ifdef PAGERANK_SUM_CONV_EN
    acc_sum  = {1'b0, acc} + {1'b0, bus.delta};
    if (bus.delta_valid) begin
      acc_next = acc_sum[DELTA_W] ? '1 : acc_sum[DELTA_W-1:0];
    end
`else
    if (bus.delta_valid && (bus.delta > acc)) begin
      acc_next = bus.delta;
    end
`endif
  end

  // Phase sequencing, partition stepping, convergence and iteration tracking.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= IDLE;
      part   <= '0;
      iter_q <= '0;
      acc    <= '0;
      thr_q  <= '0;
      conv_q <= 1'b0;
    end else if ((state != IDLE) && !bus.pagerank_enable) begin
      // Abort wins over everything, including done pulses this cycle.
      state  <= IDLE;
      part   <= '0;
      iter_q <= '0;
      acc    <= '0;
      conv_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.pagerank_enable) begin
            state  <= SC_ISSUE;
            thr_q  <= bus.threshold;
            part   <= '0;
            iter_q <= '0;
            acc    <= '0;
            conv_q <= 1'b0;
          end
        end
        SC_ISSUE: state <= SC_WAIT;
        SC_WAIT: begin
          if (bus.scatter_done) begin
            if (part == LAST_PART) begin
              state <= GA_ISSUE;
              part  <= '0;
            end else begin
              state <= SC_ISSUE;
              part  <= part + PART_W'(1);
            end
          end
        end
        GA_ISSUE: begin
          acc   <= acc_next;
          state <= GA_WAIT;
        end
        GA_WAIT: begin
          acc <= acc_next;
          if (bus.gather_done) begin
            if (part == LAST_PART) begin
              state <= CHECK;
              part  <= '0;
            end else begin
              state <= GA_ISSUE;
              part  <= part + PART_W'(1);
            end
          end
        end
        CHECK: begin
          iter_q <= iter_next;
          if (acc < thr_q) begin
            state  <= DONE;
            conv_q <= 1'b1;
          end else if (iter_next == ITER_LIMIT) begin
            state  <= DONE;
            conv_q <= 1'b0;
          end else begin
            state <= SC_ISSUE;
            acc   <= '0;
          end
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Start pulses are suppressed on an abort cycle.
  assign bus.scatter_start     = (state == SC_ISSUE) && bus.pagerank_enable;
  assign bus.gather_start      = (state == GA_ISSUE) && bus.pagerank_enable;
  assign bus.scatter_part      = in_scatter ? part : '0;
  assign bus.gather_part       = in_gather ? part : '0;
  assign bus.iter_count        = iter_q;
  assign bus.busy              = (state != IDLE) && (state != DONE);
  assign bus.pagerank_complete = (state == DONE);
  assign bus.converged         = conv_q;
endmodule

// File: tb/tb_pagerank_iter_ctrl.sv
// Bench for pagerank_iter_ctrl with two partitions and an iteration limit
// of three. A responder answers every start three cycles later; expected
// starts and run results are queued when a run is set up and consumed as
// the controller produces them.
module tb_pagerank_iter_ctrl;
  localparam int NP     = 2;
  localparam int MI     = 3;
  localparam int DW     = 32;
  localparam int PW     = $clog2(NP) + 1;
  localparam int IW     = 16;

  logic clock = 1'b0;
  logic reset_n;

  pagerank_iter_ctrl_if #(.DELTA_W(DW), .PART_W(PW), .ITER_W(IW)) ifc ();

  pagerank_iter_ctrl #(
    .NUM_PARTITIONS(NP),
    .MAX_ITER      (MI),
    .DELTA_W       (DW),
    .ITER_W        (IW)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (ifc.master)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: starts encoded kind*16+part (kind 1 = gather), results conv*65536+iter
  int              start_q[$];
  int              done_q[$];
  logic [DW-1:0]   delta_q[$];

  int              cyc = 0;
  int              rsp_cnt = 0;
  logic            rsp_gather = 1'b0;
  int              rsp_part = 0;
  logic [DW-1:0]   rsp_delta = '0;
  int              done_cyc = 0;
  int              gap_exp = 0;
  logic            gap_valid = 1'b0;
  logic            abort_on_sdone = 1'b0;
  logic            seen_gstart = 1'b0;
  int              g_cnt = 0;
  logic            prev_cmpl = 1'b0;
  logic            s_st, g_st, cmpl;
  int              e;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] combine(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
`ifdef PAGERANK_SUM_CONV_EN
    s = {1'b0, a} + {1'b0, b};
    return s[DW] ? '1 : s[DW-1:0];
`else
    s = '0;
    return (a > b) ? a : b;
`endif
  endfunction

  // Responder and output monitor: sample first, then drive the next inputs.
  always @(negedge clock) begin
    cyc++;
    s_st = ifc.scatter_start;
    g_st = ifc.gather_start;
    cmpl = ifc.pagerank_complete;
    ifc.scatter_done = 1'b0;
    ifc.gather_done  = 1'b0;
    ifc.delta_valid  = 1'b0;
    ifc.delta        = '0;
    if (rsp_cnt != 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        if (!rsp_gather) begin
          ifc.scatter_done = 1'b1;
          ifc.delta_valid  = 1'b1;
          ifc.delta        = '1;
          if (abort_on_sdone) begin
            ifc.pagerank_enable = 1'b0;
            abort_on_sdone      = 1'b0;
          end
        end else begin
          ifc.gather_done = 1'b1;
          ifc.delta_valid = 1'b1;
          ifc.delta       = rsp_delta;
        end
        done_cyc  = cyc;
        gap_exp   = (rsp_gather && rsp_part == NP - 1) ? 2 : 1;
        gap_valid = 1'b1;
      end
    end
    if (s_st || g_st) begin
      if (g_st) begin
        g_cnt++;
        seen_gstart = 1'b1;
      end
      check_eq("start_expected", 64'(start_q.size() != 0), 1);
      check_eq("start_busy", ifc.busy, 1);
      if (start_q.size() != 0) begin
        e = start_q.pop_front();
        check_eq("start_kind", g_st, 64'(e / 16));
        check_eq("start_part", g_st ? ifc.gather_part : ifc.scatter_part, 64'(e % 16));
        check_eq("other_part_zero", g_st ? ifc.scatter_part : ifc.gather_part, 0);
      end
      if (gap_valid) begin
        check_eq("start_gap", 64'(cyc - done_cyc), 64'(gap_exp));
        gap_valid = 1'b0;
      end
      rsp_cnt    = 3;
      rsp_gather = g_st;
      rsp_part   = g_st ? int'(ifc.gather_part) : int'(ifc.scatter_part);
      if (g_st) begin
        check_eq("delta_available", 64'(delta_q.size() != 0), 1);
        rsp_delta = (delta_q.size() != 0) ? delta_q.pop_front() : '0;
      end
    end
    if (cmpl && !prev_cmpl) begin
      check_eq("result_expected", 64'(done_q.size() != 0), 1);
      if (done_q.size() != 0) begin
        e = done_q.pop_front();
        check_eq("converged", ifc.converged, 64'(e / 65536));
        check_eq("iter_count", ifc.iter_count, 64'(e % 65536));
      end
      if (gap_valid) begin
        check_eq("done_gap", 64'(cyc - done_cyc), 2);
        gap_valid = 1'b0;
      end
    end
    prev_cmpl = cmpl;
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_sstart"}, ifc.scatter_start, 0);
    check_eq({tag, "_gstart"}, ifc.gather_start, 0);
    check_eq({tag, "_spart"}, ifc.scatter_part, 0);
    check_eq({tag, "_gpart"}, ifc.gather_part, 0);
    check_eq({tag, "_iter"}, ifc.iter_count, 0);
    check_eq({tag, "_busy"}, ifc.busy, 0);
    check_eq({tag, "_complete"}, ifc.pagerank_complete, 0);
    check_eq({tag, "_conv"}, ifc.converged, 0);
  endtask

  // One full run: first-iteration deltas (a0,b0), later iterations (a1,b1).
  task automatic run_case(input logic [DW-1:0] thr, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                          input logic [DW-1:0] a1, input logic [DW-1:0] b1);
    int            it;
    logic          conv;
    logic [DW-1:0] acc;
    it   = 0;
    conv = 1'b0;
    while (it < MI) begin
      for (int p = 0; p < NP; p++) start_q.push_back(p);
      for (int p = 0; p < NP; p++) start_q.push_back(16 + p);
      delta_q.push_back(it == 0 ? a0 : a1);
      delta_q.push_back(it == 0 ? b0 : b1);
      acc = combine(it == 0 ? a0 : a1, it == 0 ? b0 : b1);
      it++;
      if (acc < thr) begin
        conv = 1'b1;
        break;
      end
    end
    done_q.push_back(int'(conv) * 65536 + it);
    gap_valid           = 1'b0;
    ifc.threshold       = thr;
    ifc.pagerank_enable = 1'b1;
    step();
    ifc.threshold = ~thr;
    for (int i = 0; i < 400; i++) begin
      if (ifc.pagerank_complete) break;
      step();
    end
    check_eq("complete_seen", ifc.pagerank_complete, 1);
    check_eq("starts_left", 64'(start_q.size()), 0);
    check_eq("deltas_left", 64'(delta_q.size()), 0);
    step();
    step();
    check_eq("hold_complete", ifc.pagerank_complete, 1);
    check_eq("hold_iter", ifc.iter_count, 64'(it));
    check_eq("hold_conv", ifc.converged, 64'(conv));
    check_eq("hold_busy", ifc.busy, 0);
    ifc.pagerank_enable = 1'b0;
    step();
    check_idle_outputs("after_done");
  endtask

  initial begin
    int g_before;
    reset_n             = 1'b0;
    ifc.pagerank_enable = 1'b0;
    ifc.threshold       = '0;
    ifc.scatter_done    = 1'b0;
    ifc.gather_done     = 1'b0;
    ifc.delta_valid     = 1'b0;
    ifc.delta           = '0;
    step();
    step();
    check_idle_outputs("reset");
    reset_n = 1'b1;
    step();

    // converges on the first iteration under max-norm
    run_case(32'd100, 32'd40, 32'd99, 32'd40, 32'd99);
    // never converges: iteration limit
    run_case(32'd10, 32'd50, 32'd50, 32'd50, 32'd50);
    // equal to threshold is not converged, then converges
    run_case(32'd10, 32'd10, 32'd0, 32'd9, 32'd0);
    // near-full-scale deltas: saturation matters for the sum accumulator
    run_case(32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0);

    // abort in SC_WAIT coincident with scatter_done
    start_q.push_back(0);
    g_before            = g_cnt;
    gap_valid           = 1'b0;
    abort_on_sdone      = 1'b1;
    ifc.threshold       = 32'd100;
    ifc.pagerank_enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!ifc.pagerank_enable) break;
    end
    check_eq("abort_dropped", ifc.pagerank_enable, 0);
    step();
    check_eq("abort_busy", ifc.busy, 0);
    check_eq("abort_spart", ifc.scatter_part, 0);
    for (int i = 0; i < 10; i++) step();
    check_eq("abort_no_gather", 64'(g_cnt), 64'(g_before));
    check_eq("abort_starts_left", 64'(start_q.size()), 0);
    check_idle_outputs("abort_idle");

    // synchronous reset while in GA_WAIT
    start_q.push_back(0);
    start_q.push_back(1);
    start_q.push_back(16);
    delta_q.push_back(32'd50);
    seen_gstart         = 1'b0;
    gap_valid           = 1'b0;
    ifc.threshold       = 32'd10;
    ifc.pagerank_enable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (seen_gstart) break;
      step();
    end
    check_eq("gstart_seen", seen_gstart, 1);
    step();
    check_eq("pre_reset_busy", ifc.busy, 1);
    reset_n             = 1'b0;
    ifc.pagerank_enable = 1'b0;
    rsp_cnt             = 0;
    step();
    check_idle_outputs("mid_reset");
    check_eq("reset_starts_left", 64'(start_q.size()), 0);
    reset_n   = 1'b1;
    gap_valid = 1'b0;
    step();
    run_case(32'd100, 32'd40, 32'd99, 32'd40, 32'd99);

    check_eq("results_left", 64'(done_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
